// File: rtl/mips_multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS controller: opcodes, functs, select codes, states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field IR[5:0] for R-type
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  // One-hot instruction class; all-zero means unsupported encoding.
  typedef struct packed {
    logic addu;
    logic subu;
    logic nop;
    logic jr;
    logic lw;
    logic sw;
    logic beq;
    logic ori;
    logic lui;
    logic j;
    logic jal;
  } iclass_t;

  // Every controller output, bundled so reset can clear them in one place.
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: controller <-> datapath bundle. master = controller, slave = datapath.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the memory side stalls the controller.
interface mips_multicycle_ctrl_if;
  // datapath -> controller
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  // controller -> datapath
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ExtOp;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       instr_done;
  logic       illegal;
  logic [3:0] dbg_state;  // raw FSM state for observation

  modport master (
    input  Opcode, Funct, Zero, mem_ready,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, instr_done, illegal, dbg_state
  );

  modport slave (
    output Opcode, Funct, Zero, mem_ready,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, instr_done, illegal, dbg_state
  );
endinterface

// File: rtl/mips_multicycle_ctrl_op_classify.sv
// Purpose: decode Opcode/Funct into a one-hot instruction class plus an illegal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_opcode/i_funct (IR fields) -> o_class (one-hot), o_illegal.
module mips_op_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_class,
  output logic       o_illegal
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_class.addu = 1'b1;
          FN_SUBU: o_class.subu = 1'b1;
          FN_SLL:  o_class.nop  = 1'b1;  // only the sll-as-nop form is supported
          FN_JR:   o_class.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_LW:   o_class.lw  = 1'b1;
      OP_SW:   o_class.sw  = 1'b1;
      OP_BEQ:  o_class.beq = 1'b1;
      OP_ORI:  o_class.ori = 1'b1;
      OP_LUI:  o_class.lui = 1'b1;
      OP_J:    o_class.j   = 1'b1;
      OP_JAL:  o_class.jal = 1'b1;
      default: ;
    endcase
    o_illegal = (o_class == '0);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: Moore control FSM for the multi-cycle MIPS datapath (ALUOp + all mux selects/enables).
// Latency: 2..5 cycles per instruction with mem_ready=1; FETCH and MEMRD/MEMWR hold while mem_ready=0.
// Backpressure: mem_ready low stalls in the current memory state with the request held.
// Ports: clk, reset (sync, active-high); ctrl_bus (master modport) carries IR fields, Zero,
//        mem_ready in and every datapath control out. All outputs are 0 while reset is high.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  mips_multicycle_ctrl_if.master      ctrl_bus
);

  state_t  r_state;
  state_t  w_next;
  iclass_t w_cls;
  logic    w_illegal;
  ctl_t    w_ctl;
  ctl_t    w_out;

  mips_op_classify u_classify (
    .i_opcode  (ctrl_bus.Opcode),
    .i_funct   (ctrl_bus.Funct),
    .o_class   (w_cls),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctl  = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.alu_op    = ALUOP_ADD;
        w_ctl.pc_src    = PCSRC_ALU;
        w_ctl.ir_write  = ctrl_bus.mem_ready;
        w_ctl.pc_en     = ctrl_bus.mem_ready;
        if (ctrl_bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        w_ctl.alu_src_b = SRCB_BRANCH;
        w_ctl.ext_op    = EXT_SIGN;
        w_ctl.alu_op    = ALUOP_ADD;
        if (w_cls.addu || w_cls.subu)    w_next = S_RTYPE_EX;
        else if (w_cls.jr)               w_next = S_JR;
        else if (w_cls.lw || w_cls.sw)   w_next = S_MEMADR;
        else if (w_cls.beq)              w_next = S_BRANCH;
        else if (w_cls.ori || w_cls.lui) w_next = S_IMM_EX;
        else if (w_cls.j)                w_next = S_JUMP;
        else if (w_cls.jal)              w_next = S_JAL;
        else begin
          // nop and unsupported encodings both retire here
          w_next           = S_FETCH;
          w_ctl.instr_done = 1'b1;
          w_ctl.illegal    = w_illegal;
        end
      end
      S_RTYPE_EX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_B;
        w_ctl.alu_op    = w_cls.subu ? ALUOP_SUB : ALUOP_ADD;
        w_next          = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = REGDST_RD;
        w_ctl.mem_to_reg = M2R_ALUOUT;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEMADR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.ext_op    = EXT_SIGN;
        w_ctl.alu_op    = ALUOP_ADD;
        w_next          = w_cls.lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.iord     = 1'b1;
        if (ctrl_bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = REGDST_RT;
        w_ctl.mem_to_reg = M2R_MDR;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEMWR: begin
        w_ctl.mem_write  = 1'b1;
        w_ctl.iord       = 1'b1;
        w_ctl.instr_done = ctrl_bus.mem_ready;
        if (ctrl_bus.mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a  = 1'b1;
        w_ctl.alu_src_b  = SRCB_B;
        w_ctl.alu_op     = ALUOP_SUB;
        w_ctl.pc_src     = PCSRC_ALUOUT;
        w_ctl.pc_en      = ctrl_bus.Zero;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_IMM_EX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.ext_op    = w_cls.lui ? EXT_LUI : EXT_ZERO;
        w_ctl.alu_op    = w_cls.lui ? ALUOP_ADD : ALUOP_OR;
        w_next          = S_IMM_WB;
      end
      S_IMM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = REGDST_RT;
        w_ctl.mem_to_reg = M2R_ALUOUT;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_JUMP: begin
        w_ctl.pc_src     = PCSRC_JUMP;
        w_ctl.pc_en      = 1'b1;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_JAL: begin
        // PC already points at the next instruction, so it is the link value.
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = REGDST_RA;
        w_ctl.mem_to_reg = M2R_PC;
        w_ctl.pc_src     = PCSRC_JUMP;
        w_ctl.pc_en      = 1'b1;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_JR: begin
        w_ctl.pc_src     = PCSRC_REG;
        w_ctl.pc_en      = 1'b1;
        w_ctl.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      default: w_next = S_FETCH;  // unused encodings recover
    endcase
  end

  // Reset is synchronous to the state, but outputs must already be quiet in the reset cycle.
  assign w_out = reset ? '0 : w_ctl;

  assign ctrl_bus.PCEn       = w_out.pc_en;
  assign ctrl_bus.IorD       = w_out.iord;
  assign ctrl_bus.MemRead    = w_out.mem_read;
  assign ctrl_bus.MemWrite   = w_out.mem_write;
  assign ctrl_bus.IRWrite    = w_out.ir_write;
  assign ctrl_bus.RegWrite   = w_out.reg_write;
  assign ctrl_bus.RegDst     = w_out.reg_dst;
  assign ctrl_bus.MemtoReg   = w_out.mem_to_reg;
  assign ctrl_bus.ALUSrcA    = w_out.alu_src_a;
  assign ctrl_bus.ALUSrcB    = w_out.alu_src_b;
  assign ctrl_bus.ExtOp      = w_out.ext_op;
  assign ctrl_bus.ALUOp      = w_out.alu_op;
  assign ctrl_bus.PCSrc      = w_out.pc_src;
  assign ctrl_bus.instr_done = w_out.instr_done;
  assign ctrl_bus.illegal    = w_out.illegal;
  assign ctrl_bus.dbg_state  = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: directed bench for mips_multicycle_ctrl; expected per-cycle outputs are queued by the
//          stimulus and compared by an independent monitor on the falling edge.
// Ports: none (top-level bench).
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, mr, mw, irw, rw;
    logic [1:0] regdst, m2r;
    logic       srca;
    logic [1:0] srcb, ext, aluop, pcsrc;
    logic       done, ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if ifc ();

  mips_multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl_bus (ifc)
  );

  exp_t       q_exp[$];
  string      q_nm[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] cur_op  = 6'd0;
  logic [5:0] cur_fn  = 6'd0;

  // f6 = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite}
  function automatic exp_t ex(input logic [3:0] st, input logic [5:0] f6,
                              input logic [1:0] regdst, input logic [1:0] m2r,
                              input logic srca, input logic [1:0] srcb,
                              input logic [1:0] ext, input logic [1:0] aluop,
                              input logic [1:0] pcsrc, input logic done);
    exp_t e;
    e.st = st;
    {e.pcen, e.iord, e.mr, e.mw, e.irw, e.rw} = f6;
    e.regdst = regdst; e.m2r = m2r; e.srca = srca; e.srcb = srcb;
    e.ext = ext; e.aluop = aluop; e.pcsrc = pcsrc; e.done = done; e.ill = 1'b0;
    return e;
  endfunction

  function automatic exp_t fetch(input logic rdy);
    return ex(4'd0, {rdy, 1'b0, 1'b1, 1'b0, rdy, 1'b0}, 2'b00, 2'b00, 1'b0, 2'b01,
              2'b00, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic exp_t decode(input logic ill, input logic done);
    exp_t e;
    e = ex(4'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, done);
    e.ill = ill;
    return e;
  endfunction

  function automatic exp_t quiet(input logic [3:0] st);
    return ex(st, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  endfunction

  task automatic step(input string nm, input logic z, input logic rdy, input logic rst,
                      input exp_t e);
    @(posedge clk);
    #1;
    reset         = rst;
    ifc.Opcode    = cur_op;
    ifc.Funct     = cur_fn;
    ifc.Zero      = z;
    ifc.mem_ready = rdy;
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_nm.pop_front();
        a.st = ifc.dbg_state;
        {a.pcen, a.iord, a.mr, a.mw, a.irw, a.rw} =
          {ifc.PCEn, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.IRWrite, ifc.RegWrite};
        a.regdst = ifc.RegDst; a.m2r = ifc.MemtoReg; a.srca = ifc.ALUSrcA;
        a.srcb = ifc.ALUSrcB; a.ext = ifc.ExtOp; a.aluop = ifc.ALUOp;
        a.pcsrc = ifc.PCSrc; a.done = ifc.instr_done; a.ill = ifc.illegal;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: state got=%0d exp=%0d, outputs got=%h exp=%h",
                   nm, a.st, e.st, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.Opcode = 6'd0; ifc.Funct = 6'd0; ifc.Zero = 1'b0; ifc.mem_ready = 1'b0;

    // Reset: outputs quiet even with mem_ready high in FETCH
    step("reset0", 1'b0, 1'b1, 1'b1, quiet(4'd0));
    step("reset1", 1'b1, 1'b1, 1'b1, quiet(4'd0));

    // addu with a one-cycle fetch stall
    cur_op = 6'b000000; cur_fn = 6'b100001;
    step("addu_fetch_stall", 1'b0, 1'b0, 1'b0, fetch(1'b0));
    step("addu_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("addu_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("addu_ex", 1'b0, 1'b1, 1'b0,
         ex(4'd6, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    step("addu_wb", 1'b0, 1'b1, 1'b0,
         ex(4'd7, 6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));

    // subu
    cur_op = 6'b000000; cur_fn = 6'b100011;
    step("subu_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("subu_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("subu_ex", 1'b0, 1'b1, 1'b0,
         ex(4'd6, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    step("subu_wb", 1'b0, 1'b1, 1'b0,
         ex(4'd7, 6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));

    // lw, memory not ready for 3 cycles in MEMRD (8 cycles total)
    cur_op = 6'b100011; cur_fn = 6'b000100;
    step("lw_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("lw_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("lw_memadr", 1'b0, 1'b1, 1'b0,
         ex(4'd2, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
    for (int i = 0; i < 3; i++)
      step("lw_memrd_wait", 1'b0, 1'b0, 1'b0,
           ex(4'd3, 6'b011000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    step("lw_memrd_rdy", 1'b0, 1'b1, 1'b0,
         ex(4'd3, 6'b011000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    step("lw_memwb", 1'b0, 1'b1, 1'b0,
         ex(4'd4, 6'b000001, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));

    // sw, ready immediately
    cur_op = 6'b101011; cur_fn = 6'b000000;
    step("sw_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("sw_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("sw_memadr", 1'b0, 1'b1, 1'b0,
         ex(4'd2, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
    step("sw_memwr", 1'b0, 1'b1, 1'b0,
         ex(4'd5, 6'b010100, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));

    // beq taken (Zero high throughout; only BRANCH may use it)
    cur_op = 6'b000100; cur_fn = 6'b000000;
    step("beqt_fetch", 1'b1, 1'b1, 1'b0, fetch(1'b1));
    step("beqt_decode", 1'b1, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("beqt_branch", 1'b1, 1'b1, 1'b0,
         ex(4'd8, 6'b100000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1));
    // beq not taken
    step("beqn_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("beqn_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("beqn_branch", 1'b0, 1'b1, 1'b0,
         ex(4'd8, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1));

    // lui
    cur_op = 6'b001111; cur_fn = 6'b100001;
    step("lui_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("lui_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("lui_ex", 1'b0, 1'b1, 1'b0,
         ex(4'd9, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0));
    step("lui_wb", 1'b0, 1'b1, 1'b0,
         ex(4'd10, 6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));

    // ori
    cur_op = 6'b001101; cur_fn = 6'b100011;
    step("ori_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("ori_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("ori_ex", 1'b0, 1'b1, 1'b0,
         ex(4'd9, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    step("ori_wb", 1'b0, 1'b1, 1'b0,
         ex(4'd10, 6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));

    // j
    cur_op = 6'b000010; cur_fn = 6'b001000;
    step("j_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("j_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("j_jump", 1'b0, 1'b1, 1'b0,
         ex(4'd11, 6'b100000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));

    // jal
    cur_op = 6'b000011; cur_fn = 6'b000000;
    step("jal_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("jal_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("jal_jal", 1'b0, 1'b1, 1'b0,
         ex(4'd12, 6'b100001, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));

    // jr
    cur_op = 6'b000000; cur_fn = 6'b001000;
    step("jr_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("jr_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("jr_jr", 1'b0, 1'b1, 1'b0,
         ex(4'd13, 6'b100000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1));

    // sll nop: retires in DECODE, not illegal
    cur_op = 6'b000000; cur_fn = 6'b000000;
    step("nop_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("nop_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b1));

    // illegal opcode 111111
    cur_op = 6'b111111; cur_fn = 6'b100001;
    step("illop_fetch", 1'b1, 1'b1, 1'b0, fetch(1'b1));
    step("illop_decode", 1'b1, 1'b1, 1'b0, decode(1'b1, 1'b1));

    // illegal R-type funct (add, 100000)
    cur_op = 6'b000000; cur_fn = 6'b100000;
    step("illfn_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("illfn_decode", 1'b0, 1'b1, 1'b0, decode(1'b1, 1'b1));

    // sw aborted by reset during the memory wait
    cur_op = 6'b101011; cur_fn = 6'b000000;
    step("swr_fetch", 1'b0, 1'b1, 1'b0, fetch(1'b1));
    step("swr_decode", 1'b0, 1'b1, 1'b0, decode(1'b0, 1'b0));
    step("swr_memadr", 1'b0, 1'b1, 1'b0,
         ex(4'd2, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
    step("swr_memwr_wait", 1'b0, 1'b0, 1'b0,
         ex(4'd5, 6'b010100, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    step("swr_reset", 1'b0, 1'b1, 1'b1, quiet(4'd5));
    step("swr_after_reset", 1'b0, 1'b0, 1'b0, fetch(1'b0));

    // Drain: every queued expectation must have been consumed by the monitor.
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending expectations got=%0d required=0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
